// File: rtl/uni2bin_win.sv
// rtl/uni2bin_win.sv - counts the ones in a unary bitstream over a window of 2^BW samples
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin one conversion window (honoured in IDLE, or in HOLD during handshake)
//   abort      synchronous cancel; forces IDLE on the next edge, highest priority
//   in         unary bitstream sample, used only while accumulating
//   out_ready  downstream accepts the held result
//   out_valid  out_data holds a completed result (registered)
//   out_data   count of ones in the last completed window, 0..2^BW (registered)
//   busy       window in progress (registered)
module uni2bin_win #(
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          in,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [BW:0]   out_data,
    output logic          busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state;
    logic [BW-1:0] sample_cnt;
    logic [BW:0]   ones_cnt;
    logic [BW:0]   ones_next;
    logic          last_sample;

    // The ones counter is one bit wider than the sample counter, so an
    // all-ones window reaches exactly 2^BW without wrapping.
    assign ones_next   = ones_cnt + {{BW{1'b0}}, in};
    assign last_sample = (sample_cnt == {BW{1'b1}});

    // busy and out_valid are kept as their own flops (mirroring state) so
    // every output comes straight from a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sample_cnt <= '0;
            ones_cnt   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else if (abort) begin
            // Partial count is abandoned; out_data keeps its last value.
            state     <= S_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_ACC;
                        busy       <= 1'b1;
                        sample_cnt <= '0;
                        ones_cnt   <= '0;
                    end
                end
                S_ACC: begin
                    sample_cnt <= sample_cnt + 1'b1;
                    ones_cnt   <= ones_next;
                    if (last_sample) begin
                        // Final sample is folded into the published count.
                        state     <= S_HOLD;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= ones_next;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            // Back-to-back window with no idle cycle.
                            state      <= S_ACC;
                            busy       <= 1'b1;
                            sample_cnt <= '0;
                            ones_cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uni2bin_win.sv
// tb/tb_uni2bin_win.sv - directed self-checking bench for uni2bin_win with BW=4
module tb_uni2bin_win;

    localparam int BW = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_bit;
    logic          out_ready;
    logic          out_valid;
    logic [BW:0]   out_data;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    uni2bin_win #(.BW(BW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in        (in_bit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that accepted start. Feeds 16 samples
    // (pattern bit i is sample i+1), optionally re-pulsing start at one
    // sample, then checks the result appears on the 16th sample edge.
    task automatic run_window(input string tag, input logic [15:0] pattern,
                              input int restart_at, input logic [31:0] exp_count);
        int busy_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (busy === 1'b1) busy_cycles++;
            in_bit = pattern[i];
            start  = (i == restart_at);
            if (i == 15) check({tag, "_valid_early"}, out_valid, 0);
            tick();
        end
        in_bit = 1'b0;
        start  = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, exp_count);
        check({tag, "_busy_off"}, busy, 0);
        check({tag, "_busy_cycles"}, busy_cycles, 16);
    endtask

    task automatic accept_to_idle(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, out_valid, 0);
        check({tag, "_idle_busy"}, busy, 0);
    endtask

    logic [BW:0] held;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        #3;
        check("reset_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_data", out_data, 0);
        tick();
        tick();

        // Start on the very first edge after reset release.
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("first_edge_start", busy, 1);
        run_window("all_ones", 16'hFFFF, -1, 16);
        accept_to_idle("all_ones");

        start = 1'b1; tick(); start = 1'b0;
        run_window("all_zero", 16'h0000, -1, 0);
        accept_to_idle("all_zero");

        start = 1'b1; tick(); start = 1'b0;
        run_window("alternate", 16'h5555, -1, 8);
        accept_to_idle("alternate");

        start = 1'b1; tick(); start = 1'b0;
        run_window("ends", 16'h8001, -1, 2);

        // Hold the result with out_ready low; start during that is ignored.
        for (int k = 0; k < 5; k++) begin
            start = (k >= 3);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 2);
            check("hold_busy", busy, 0);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", out_valid, 0);
        run_window("b2b", 16'h00FF, -1, 8);
        accept_to_idle("b2b");

        // start re-pulsed at sample 7 must not restart the window.
        start = 1'b1; tick(); start = 1'b0;
        run_window("restart_ignored", 16'h7777, 6, 12);

        // abort in HOLD beats handshake and start; data is kept.
        abort = 1'b1; out_ready = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; out_ready = 1'b0; start = 1'b0;
        check("abort_hold_valid", out_valid, 0);
        check("abort_hold_busy", busy, 0);
        check("abort_hold_data", out_data, 12);
        tick();
        check("abort_hold_stays_idle", busy, 0);

        // abort after 10 samples.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_bit = 1'b1;
            tick();
        end
        in_bit = 1'b0;
        abort  = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_acc_busy", busy, 0);
        check("abort_acc_valid", out_valid, 0);
        check("abort_acc_data", out_data, 12);
        held = out_data;
        tick();
        check("abort_idle_stable", out_data, held);
        start = 1'b1; tick(); start = 1'b0;
        run_window("after_abort", 16'hFFFF, -1, 16);
        accept_to_idle("after_abort");

        // Asynchronous reset mid-window, between edges.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'b1;
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        tick();
        rst_n  = 1'b1;
        in_bit = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("post_rst_no_valid", out_valid, 0);
            check("post_rst_idle", busy, 0);
        end
        in_bit = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        run_window("after_reset", 16'h0001, -1, 1);
        accept_to_idle("after_reset");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/uni2bin_win.md
UNI2BIN_WIN -- requirements
Module: uni2bin_win

Interface
REQ-001 SHALL have parameter BW, default 8, meaning log2 of the window length (window = 2^BW cycles); legal range 1..16.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin one conversion window.
REQ-005 SHALL have port abort  input  1  synchronous cancel of the current window or held result.
REQ-006 SHALL have port in  input  1  unary bitstream, e.g. the output of the sqrt stage.
REQ-007 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-008 SHALL have port out_valid  output  1  out_data holds a completed result.
REQ-009 SHALL have port out_data  output  BW+1  count of ones seen in the last completed window (0..2^BW).
REQ-010 SHALL have port busy  output  1  window in progress.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ACC, HOLD.
REQ-012 SHALL have a BW-bit sample counter and a (BW+1)-bit ones counter, both registered.
REQ-013 IDLE: SHALL go to ACC when start=1, clearing both counters to 0 on that edge.
REQ-014 ACC: on every edge, SHALL increment the sample counter and add in (0 or 1) to the ones counter.
REQ-015 ACC: on the edge that takes sample number 2^BW (sample counter = 2^BW-1), SHALL go to HOLD and load out_data with the final count, including that last sample.
REQ-016 Latency: start is accepted on edge t, samples are taken on edges t+1..t+2^BW, and out_valid SHALL be 1 from edge t+2^BW.
REQ-017 Ones counter SHALL NOT wrap: all-ones input yields out_data = 2^BW exactly.
REQ-018 start SHALL be ignored in ACC; the window is not restarted.
REQ-019 HOLD: out_valid=1 and out_data SHALL stay stable until out_valid and out_ready are both 1 on an edge.
REQ-020 HOLD with out_ready=1: SHALL go to IDLE, or to ACC with cleared counters if start=1 on the same edge (back-to-back windows, no idle cycle).
REQ-021 HOLD with out_ready=0: start SHALL be ignored.
REQ-022 abort=1 SHALL force IDLE on the next edge from any state, and SHALL take priority over start, window completion and handshake.
REQ-023 abort SHALL leave out_data at its last value, while out_valid drops to 0.
REQ-024 busy SHALL be 1 exactly when state = ACC; out_valid SHALL be 1 exactly when state = HOLD.
REQ-025 in SHALL be don't-care outside ACC; counters SHALL NOT change in IDLE or HOLD.
REQ-026 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 SHALL immediately set state=IDLE, both counters=0, out_data=0, out_valid=0 and busy=0, independent of clk.
REQ-028 Reset asserted mid-window SHALL discard the partial count; after release the block waits in IDLE for start.
REQ-029 On the first edge after rst_n deasserts, start SHALL be honoured.

Verification
REQ-030 BW=4, pulse start, in=1 for 16 cycles -> out_valid rises at edge t+16 with out_data=16; busy high for exactly 16 cycles.
REQ-031 BW=4, in=0 throughout -> out_data=0; in alternating 1,0 -> out_data=8.
REQ-032 BW=4, result in HOLD, out_ready=0 for 5 cycles, then 1 together with start=1 -> data stable for 5 cycles, then ACC entered with no IDLE gap; second window count is correct.
REQ-033 start re-pulsed at sample 7 of a window -> ignored; result arrives at the original edge t+16.
REQ-034 abort at sample 10 -> IDLE next edge, busy=0, out_valid=0; a fresh start then gives a correct full count.
REQ-035 rst_n pulsed low at sample 5 (asynchronous, between edges) -> outputs 0 immediately; no out_valid until a new start completes.
